// File: rtl/sema_pkg.sv
// Shared types and helpers for the bit-byte semaphore receive path.
package sema_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } sema_rx_state_t;

    localparam int unsigned SEMA_DEF_DATA_W = 8;

    // Width of a counter that must reach DATA_W inclusive.
    function automatic int unsigned sema_cnt_w(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/sema_rx_shift.sv
// Bit-collecting shift register: places incoming bits, counts them, and can
// park one complete word while the output buffer is occupied.
module sema_rx_shift
    import sema_pkg::*;
#(
    parameter int unsigned DATA_W    = SEMA_DEF_DATA_W,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_bit,
    input  logic                          i_accept,
    input  logic                          i_sync,
    input  logic                          i_park,
    input  logic                          i_drain,
    output logic [DATA_W-1:0]             o_sh,
    output logic [DATA_W-1:0]             o_word,
    output logic [sema_cnt_w(DATA_W)-1:0] o_cnt,
    output logic                          o_last_bit
);

    localparam int unsigned CNT_W = sema_cnt_w(DATA_W);

    logic [DATA_W-1:0] r_sh;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_pos;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_word;
    logic              w_last_bit;

    // Word as it would look with the current bit merged in.
    always_comb begin
        w_pos  = MSB_FIRST ? (CNT_W'(DATA_W - 1) - r_cnt) : r_cnt;
        w_mask = DATA_W'(1) << w_pos;
        w_word = i_bit ? (r_sh | w_mask) : (r_sh & ~w_mask);
    end

    assign w_last_bit = i_accept && !i_sync && (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_sync || i_drain) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_accept) begin
            if (w_last_bit && !i_park) begin
                r_sh  <= '0;
                r_cnt <= '0;
            end else if (w_last_bit) begin
                r_sh  <= w_word;
                r_cnt <= CNT_W'(DATA_W);
            end else begin
                r_sh  <= w_word;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sh       = r_sh;
    assign o_word     = w_word;
    assign o_cnt      = r_cnt;
    assign o_last_bit = w_last_bit;

endmodule

// File: rtl/sema_byte_rx.sv
// Semaphore reader-side deserializer: bits in, DATA_W-bit words out through a
// one-entry output buffer; stalls the semaphore only when a second word is parked.
module sema_byte_rx
    import sema_pkg::*;
#(
    parameter int unsigned DATA_W    = SEMA_DEF_DATA_W,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                          clk_s,
    input  logic                          rstn_s,
    input  logic                          sema_data_i_s,
    input  logic                          sema_valid_i_s,
    output logic                          sema_ready_o_s,
    input  logic                          sync_i_s,
    output logic [DATA_W-1:0]             byte_data_o_s,
    output logic                          byte_valid_o_s,
    input  logic                          byte_ready_i_s,
    output logic [sema_cnt_w(DATA_W)-1:0] bit_cnt_o_s
);

    sema_rx_state_t    r_state;
    sema_rx_state_t    w_state_nxt;
    logic              r_ready;
    logic              r_ob_v;
    logic [DATA_W-1:0] r_ob;
    logic              w_ob_v_nxt;
    logic [DATA_W-1:0] w_ob_nxt;
    logic              w_park;
    logic              w_drain;
    logic              w_accept;
    logic              w_word_fire;
    logic              w_last_bit;
    logic [DATA_W-1:0] w_sh;
    logic [DATA_W-1:0] w_word;

    assign w_accept    = sema_valid_i_s && r_ready;
    assign w_word_fire = r_ob_v && byte_ready_i_s;

    sema_rx_shift #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .i_clk      (clk_s),
        .i_rstn     (rstn_s),
        .i_bit      (sema_data_i_s),
        .i_accept   (w_accept),
        .i_sync     (sync_i_s),
        .i_park     (w_park),
        .i_drain    (w_drain),
        .o_sh       (w_sh),
        .o_word     (w_word),
        .o_cnt      (bit_cnt_o_s),
        .o_last_bit (w_last_bit)
    );

    // Next state and output-buffer update.
    always_comb begin
        w_state_nxt = r_state;
        w_ob_nxt    = r_ob;
        w_ob_v_nxt  = r_ob_v && !w_word_fire;
        w_park      = 1'b0;
        w_drain     = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_last_bit) begin
                    if (!r_ob_v || w_word_fire) begin
                        w_ob_nxt   = w_word;
                        w_ob_v_nxt = 1'b1;
                    end else begin
                        w_park      = 1'b1;
                        w_state_nxt = FULL;
                    end
                end
            end
            FULL: begin
                // Sync throws away the parked word rather than forwarding it.
                if (sync_i_s) begin
                    w_state_nxt = COLLECT;
                end else if (w_word_fire) begin
                    w_ob_nxt    = w_sh;
                    w_ob_v_nxt  = 1'b1;
                    w_drain     = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk_s) begin
        if (!rstn_s) begin
            r_state <= COLLECT;
            r_ready <= 1'b0;
            r_ob_v  <= 1'b0;
            r_ob    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == COLLECT);
            r_ob_v  <= w_ob_v_nxt;
            r_ob    <= w_ob_nxt;
        end
    end

    assign sema_ready_o_s = r_ready;
    assign byte_valid_o_s = r_ob_v;
    assign byte_data_o_s  = r_ob;

endmodule

// File: tb/tb_sema_byte_rx.sv
// Bench for sema_byte_rx: directed scenarios plus randomized traffic against a
// word-queue reference model, on an LSB-first and an MSB-first instance.
module tb_sema_byte_rx;

    logic       clk;
    logic       rstn;
    logic       sdata;
    logic       svalid;
    logic       sync;
    logic       bready;
    logic       ready_l, ready_m;
    logic       valid_l, valid_m;
    logic [7:0] data_l, data_m;
    logic [3:0] cnt_l, cnt_m;

    int checks;
    int failures;

    // Reference model: completed words queue (front = output buffer, second = parked word).
    int         m_part;
    logic [7:0] m_acc;
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    bit         m_ready;

    sema_byte_rx #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk_s(clk), .rstn_s(rstn), .sema_data_i_s(sdata), .sema_valid_i_s(svalid),
        .sema_ready_o_s(ready_l), .sync_i_s(sync), .byte_data_o_s(data_l),
        .byte_valid_o_s(valid_l), .byte_ready_i_s(bready), .bit_cnt_o_s(cnt_l)
    );

    sema_byte_rx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk_s(clk), .rstn_s(rstn), .sema_data_i_s(sdata), .sema_valid_i_s(svalid),
        .sema_ready_o_s(ready_m), .sync_i_s(sync), .byte_data_o_s(data_m),
        .byte_valid_o_s(valid_m), .byte_ready_i_s(bready), .bit_cnt_o_s(cnt_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Drive one cycle, advance the model across the edge, settle 1 time unit.
    task automatic step(input bit v, input bit b, input bit s, input bit r, input bit rst_n);
        int  pre;
        bit  fire;
        bit  acc;
        svalid = v; sdata = b; sync = s; bready = r; rstn = rst_n;
        @(posedge clk);
        if (!rst_n) begin
            m_part = 0; m_acc = '0; m_q.delete(); m_last = '0; m_ready = 1'b0;
        end else begin
            pre  = m_q.size();
            fire = (pre > 0) && r;
            acc  = v && m_ready;
            if (fire) m_last = m_q.pop_front();
            if (s) begin
                m_part = 0; m_acc = '0;
                if (pre == 2) void'(m_q.pop_back());
            end else if (acc) begin
                m_acc[m_part] = b;
                m_part++;
                if (m_part == 8) begin
                    m_q.push_back(m_acc);
                    m_part = 0; m_acc = '0;
                end
            end
            m_ready = (m_q.size() < 2);
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (ready_l !== 1'b0 || ready_m !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b/%b exp=0", ready_l, ready_m); end
        checks++; if (valid_l !== 1'b0 || valid_m !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b/%b exp=0", valid_l, valid_m); end
        checks++; if (data_l !== 8'h00 || data_m !== 8'h00) begin failures++; $display("FAIL reset_data got=%h/%h exp=00", data_l, data_m); end
        checks++; if (cnt_l !== 4'd0 || cnt_m !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0", cnt_l, cnt_m); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (ready_l !== 1'b1 || ready_m !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b/%b exp=1", ready_l, ready_m); end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        do_reset();
        w = 8'h4D;
        for (int j = 0; j < 8; j++) begin
            step(1'b1, w[j], 1'b0, 1'b1, 1'b1);
            if (j == 6) begin
                checks++; if (valid_l !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", valid_l); end
            end
        end
        checks++; if (valid_l !== 1'b1 || valid_m !== 1'b1) begin failures++; $display("FAIL single_valid got=%b/%b exp=1", valid_l, valid_m); end
        checks++; if (data_l !== 8'h4D) begin failures++; $display("FAIL single_lsb_data got=%h exp=4d", data_l); end
        checks++; if (data_m !== 8'hB2) begin failures++; $display("FAIL single_msb_data got=%h exp=b2", data_m); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (valid_l !== 1'b0 || valid_m !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%b/%b exp=0", valid_l, valid_m); end
    endtask

    task automatic test_backpressure();
        logic [15:0] w;
        do_reset();
        w = 16'hA54D;
        for (int j = 0; j < 16; j++) begin
            step(1'b1, w[j], 1'b0, 1'b0, 1'b1);
            if (j == 14) begin
                checks++; if (ready_l !== 1'b1) begin failures++; $display("FAIL bp_ready_before got=%b exp=1", ready_l); end
            end
        end
        checks++; if (ready_l !== 1'b0 || ready_m !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b/%b exp=0", ready_l, ready_m); end
        checks++; if (cnt_l !== 4'd8 || cnt_m !== 4'd8) begin failures++; $display("FAIL bp_cnt got=%0d/%0d exp=8", cnt_l, cnt_m); end
        checks++; if (data_l !== 8'h4D || valid_l !== 1'b1) begin failures++; $display("FAIL bp_held got=%h v=%b exp=4d v=1", data_l, valid_l); end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (cnt_l !== 4'd8 || data_l !== 8'h4D) begin failures++; $display("FAIL bp_stall got=%0d %h exp=8 4d", cnt_l, data_l); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (data_l !== 8'hA5 || data_m !== 8'hA5) begin failures++; $display("FAIL bp_drain_data got=%h/%h exp=a5", data_l, data_m); end
        checks++; if (ready_l !== 1'b1 || valid_l !== 1'b1 || cnt_l !== 4'd0) begin failures++; $display("FAIL bp_drain_state got=r%b v%b c%0d exp=r1 v1 c0", ready_l, valid_l, cnt_l); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (valid_l !== 1'b0) begin failures++; $display("FAIL bp_final_consume got=%b exp=0", valid_l); end
    endtask

    task automatic test_sync();
        int nwords;
        logic [7:0] seen;
        do_reset();
        for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (cnt_l !== 4'd3) begin failures++; $display("FAIL sync_pre_cnt got=%0d exp=3", cnt_l); end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (cnt_l !== 4'd0 || cnt_m !== 4'd0) begin failures++; $display("FAIL sync_cnt got=%0d/%0d exp=0", cnt_l, cnt_m); end
        nwords = 0; seen = '0;
        for (int j = 0; j < 10; j++) begin
            step(j < 8, 1'b1, 1'b0, 1'b1, 1'b1);
            if (valid_l) begin nwords++; seen = data_l; end
        end
        checks++; if (nwords != 1 || seen !== 8'hFF) begin failures++; $display("FAIL sync_word got=%0d words %h exp=1 words ff", nwords, seen); end
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        int sent;
        int nwords;
        logic [7:0] seen;
        do_reset();
        w = 8'h3C; sent = 0; nwords = 0; seen = '0;
        for (int i = 0; i < 26; i++) begin
            if (i % 3 == 0 && sent < 8) begin
                step(1'b1, w[sent], 1'b0, 1'b1, 1'b1);
                sent++;
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
                if (i == 10) begin
                    checks++; if (cnt_l !== 4'd4) begin failures++; $display("FAIL gap_cnt_hold got=%0d exp=4", cnt_l); end
                end
            end
            if (valid_l) begin nwords++; seen = data_l; end
        end
        checks++; if (nwords != 1 || seen !== 8'h3C) begin failures++; $display("FAIL gap_word got=%0d words %h exp=1 words 3c", nwords, seen); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        logic [7:0]  f;
        int nwords;
        do_reset();
        for (int j = 0; j < 5; j++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (cnt_l !== 4'd0 || ready_l !== 1'b0 || valid_l !== 1'b0 || data_l !== 8'h00) begin failures++; $display("FAIL rst_mid got=c%0d r%b v%b d%h exp=0", cnt_l, ready_l, valid_l, data_l); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        w = 16'h1234;
        for (int j = 0; j < 16; j++) step(1'b1, w[j], 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (cnt_l !== 4'd0 || ready_l !== 1'b0 || valid_l !== 1'b0 || data_l !== 8'h00 || data_m !== 8'h00) begin failures++; $display("FAIL rst_full got=c%0d r%b v%b d%h exp=0", cnt_l, ready_l, valid_l, data_l); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        f = 8'h81; nwords = 0;
        for (int j = 0; j < 10; j++) begin
            step(j < 8, (j < 8) ? f[j[2:0]] : 1'b0, 1'b0, 1'b1, 1'b1);
            if (valid_l) begin
                nwords++;
                checks++; if (data_l !== 8'h81 || data_m !== 8'h81) begin failures++; $display("FAIL rst_fresh_data got=%h/%h exp=81", data_l, data_m); end
            end
        end
        checks++; if (nwords != 1) begin failures++; $display("FAIL rst_fresh_count got=%0d exp=1", nwords); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a;
        logic [15:0] s;
        do_reset();
        a = 8'h4D;
        for (int j = 0; j < 8; j++) step(1'b1, a[j], 1'b0, 1'b0, 1'b1);
        a = 8'hA5;
        for (int j = 0; j < 8; j++) begin
            step(1'b1, a[j], 1'b0, j == 7, 1'b1);
            checks++; if (ready_l !== 1'b1) begin failures++; $display("FAIL b2b_ready_drop step=%0d got=%b exp=1", j, ready_l); end
        end
        checks++; if (data_l !== 8'hA5 || valid_l !== 1'b1 || cnt_l !== 4'd0) begin failures++; $display("FAIL b2b_swap got=%h v%b c%0d exp=a5 v1 c0", data_l, valid_l, cnt_l); end
        s = 16'($urandom());
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, s[k-1], 1'b0, 1'b1, 1'b1);
            checks++; if (valid_l !== (k % 8 == 0) || ready_l !== 1'b1) begin failures++; $display("FAIL b2b_stream k=%0d got=v%b r%b exp=v%b r1", k, valid_l, ready_l, (k % 8 == 0)); end
            if (k == 8) begin
                checks++; if (data_l !== s[7:0] || data_m !== rev8(s[7:0])) begin failures++; $display("FAIL b2b_w1 got=%h/%h exp=%h", data_l, data_m, s[7:0]); end
            end
            if (k == 16) begin
                checks++; if (data_l !== s[15:8] || data_m !== rev8(s[15:8])) begin failures++; $display("FAIL b2b_w2 got=%h/%h exp=%h", data_l, data_m, s[15:8]); end
            end
        end
    endtask

    task automatic test_random();
        bit         v, b, s, r, rn;
        logic [7:0] e_d;
        logic [3:0] e_c;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom_range(0, 1));
            s  = ($urandom_range(0, 60) == 0);
            r  = ((i / 400) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            rn = ($urandom_range(0, 300) != 0);
            step(v, b, s, r, rn);
            e_d = (m_q.size() > 0) ? m_q[0] : m_last;
            e_c = (m_q.size() == 2) ? 4'd8 : 4'(m_part);
            checks++; if (ready_l !== m_ready || ready_m !== m_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b/%b exp=%b", i, ready_l, ready_m, m_ready); end
            checks++; if (valid_l !== (m_q.size() > 0) || valid_m !== (m_q.size() > 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b", i, valid_l, valid_m, m_q.size() > 0); end
            checks++; if (data_l !== e_d || data_m !== rev8(e_d)) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h/%h exp=%h/%h", i, data_l, data_m, e_d, rev8(e_d)); end
            checks++; if (cnt_l !== e_c || cnt_m !== e_c) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d", i, cnt_l, cnt_m, e_c); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        m_part = 0; m_acc = '0; m_last = '0; m_ready = 1'b0;
        rstn = 1'b0; sdata = 1'b0; svalid = 1'b0; sync = 1'b0; bready = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_sync();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
